// File: rtl/mul_32bit_precion_control.sv
// SIMD multiplier: 4x8, 2x16 or 1x32 lanes selected at run time, with MUL/MULH/MULHU/MULHSU.
// Latency 1 with combinational output, latency 2 when MUL_OUTPUT_REG_EN is defined; no backpressure, one op per cycle.
module mul_32bit_precion_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] operand_a_reg,
  input  logic [31:0] operand_b_reg,
  input  logic [1:0]  opcode_reg,
  input  logic [1:0]  precision_reg,
  output logic [31:0] mul_out
);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b10;
  localparam logic [1:0] OP_MULHSU = 2'b11;

  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  prec_q, prec_d;
  logic [31:0] res;

  // Sign-extends each lane from its own top bit, so no sign ever leaks across lanes.
  function automatic logic [63:0] lane_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb,
                                            input logic [1:0] prec);
    logic signed [32:0] ae;
    logic signed [32:0] be;
    logic signed [65:0] p;
    case (prec)
      2'b00: begin
        ae = {{25{sa & a[7]}}, a[7:0]};
        be = {{25{sb & b[7]}}, b[7:0]};
      end
      2'b01: begin
        ae = {{17{sa & a[15]}}, a[15:0]};
        be = {{17{sb & b[15]}}, b[15:0]};
      end
      default: begin
        ae = {sa & a[31], a};
        be = {sb & b[31], b};
      end
    endcase
    p = ae * be;
    return p[63:0];
  endfunction

  always_comb begin
    a_d    = operand_a_reg;
    b_d    = operand_b_reg;
    op_d   = opcode_reg;
    prec_d = precision_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      prec_q <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      prec_q <= prec_d;
    end
  end

  always_comb begin
    logic        sa;
    logic        sb;
    logic        hi;
    logic [63:0] p;
    sa  = (op_q != OP_MULHU);
    sb  = (op_q != OP_MULHU) && (op_q != OP_MULHSU);
    hi  = (op_q != OP_MUL);
    res = '0;
    p   = '0;
    case (prec_q)
      2'b00: begin
        for (int i = 0; i < 4; i++) begin
          p = lane_prod({24'b0, a_q[8*i +: 8]}, {24'b0, b_q[8*i +: 8]}, sa, sb, prec_q);
          res[8*i +: 8] = hi ? p[15:8] : p[7:0];
        end
      end
      2'b01: begin
        for (int i = 0; i < 2; i++) begin
          p = lane_prod({16'b0, a_q[16*i +: 16]}, {16'b0, b_q[16*i +: 16]}, sa, sb, prec_q);
          res[16*i +: 16] = hi ? p[31:16] : p[15:0];
        end
      end
      default: begin
        p   = lane_prod(a_q, b_q, sa, sb, prec_q);
        res = hi ? p[63:32] : p[31:0];
      end
    endcase
  end

`ifdef MUL_OUTPUT_REG_EN
  logic [31:0] out_q, out_d;

  always_comb out_d = res;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_q <= '0;
    else      out_q <= out_d;
  end

  assign mul_out = out_q;
`else
  assign mul_out = res;
`endif

endmodule

// File: tb/tb_mul_32bit_precion_control.sv
// Randomized + directed bench for mul_32bit_precion_control against an integer-arithmetic lane model.
module tb_mul_32bit_precion_control;

`ifdef MUL_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] operand_a_reg = '0;
  logic [31:0] operand_b_reg = '0;
  logic [1:0]  opcode_reg = '0;
  logic [1:0]  precision_reg = '0;
  logic [31:0] mul_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  mul_32bit_precion_control dut (
    .clk           (clk),
    .rst           (rst),
    .operand_a_reg (operand_a_reg),
    .operand_b_reg (operand_b_reg),
    .opcode_reg    (opcode_reg),
    .precision_reg (precision_reg),
    .mul_out       (mul_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Per-lane product of signed/unsigned integers, then pick the low or high W bits.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, input logic [1:0] pr);
    int          w;
    longint      mask, ua, ub, va, vb, p, r;
    logic [31:0] out;
    bit          sa, sb;
    w    = (pr == 2'b00) ? 8 : (pr == 2'b01) ? 16 : 32;
    mask = (longint'(1) << w) - 1;
    sa   = (op != 2'b10);
    sb   = (op == 2'b00) || (op == 2'b01);
    out  = '0;
    for (int i = 0; i < 32 / w; i++) begin
      ua = (longint'(a) >> (w * i)) & mask;
      ub = (longint'(b) >> (w * i)) & mask;
      va = (sa && ua[w-1]) ? ua - (longint'(1) << w) : ua;
      vb = (sb && ub[w-1]) ? ub - (longint'(1) << w) : ub;
      p  = va * vb;
      r  = (op == 2'b00) ? (p & mask) : ((p >> w) & mask);
      out = out | 32'(r << (w * i));
    end
    return out;
  endfunction

  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [1:0] pr);
    @(negedge clk);
    if (exp_q.size() >= LAT) check(tag_q.pop_front(), mul_out, exp_q.pop_front());
    operand_a_reg = a;
    operand_b_reg = b;
    opcode_reg    = op;
    precision_reg = pr;
    exp_q.push_back(ref_mul(a, b, op, pr));
    tag_q.push_back(tag);
  endtask

  task automatic restart_pipe();
    exp_q.delete();
    tag_q.delete();
    for (int i = 0; i < LAT - 1; i++) begin
      exp_q.push_back(32'h0);
      tag_q.push_back("post_reset_zero");
    end
  endtask

  initial begin
    #3;
    check("reset_out", mul_out, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    restart_pipe();

    step("mul32_neg1x2",   32'hFFFF_FFFF, 32'h0000_0002, 2'b00, 2'b10);
    step("mulhu8_ff",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 2'b00);
    step("mulh8_minneg",   32'h8080_8080, 32'h8080_8080, 2'b01, 2'b00);
    step("mul8_minneg",    32'h8080_8080, 32'h8080_8080, 2'b00, 2'b00);
    step("mulhsu16_ff",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 2'b01);
    step("mulhu16_ff",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 2'b01);
    step("mulh32_minneg",  32'h8000_0000, 32'h8000_0000, 2'b01, 2'b10);
    step("prec11_mulhsu",  32'h8000_0001, 32'hFFFF_FFFF, 2'b11, 2'b11);
    step("mulh8_mixed",    32'h7F80_01FF, 32'h7F7F_80FF, 2'b01, 2'b00);

    // Directed values checked independently of the model.
    begin
      logic [31:0] k [0:6];
      k = '{32'hFFFF_FFFE, 32'hFEFE_FEFE, 32'h4040_4040, 32'h0000_0000,
            32'hFFFF_FFFF, 32'hFFFE_FFFE, 32'h4000_0000};
      check("model_req025", ref_mul(32'hFFFF_FFFF, 32'h2, 2'b00, 2'b10), k[0]);
      check("model_req026", ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 2'b00), k[1]);
      check("model_req027h", ref_mul(32'h8080_8080, 32'h8080_8080, 2'b01, 2'b00), k[2]);
      check("model_req027l", ref_mul(32'h8080_8080, 32'h8080_8080, 2'b00, 2'b00), k[3]);
      check("model_req028s", ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 2'b01), k[4]);
      check("model_req028u", ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 2'b01), k[5]);
      check("model_req029", ref_mul(32'h8000_0000, 32'h8000_0000, 2'b01, 2'b10), k[6]);
    end

    for (int i = 0; i < 300; i++)
      step("random", $urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

    // Mid-stream reset with nonzero operands in flight.
    step("pre_reset", 32'h1234_5678, 32'h9ABC_DEF0, 2'b00, 2'b01);
    step("pre_reset", 32'hDEAD_BEEF, 32'h0BAD_F00D, 2'b01, 2'b10);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", mul_out, 32'h0);
    @(negedge clk);
    check("reset_hold", mul_out, 32'h0);
    rst = 1'b1;
    restart_pipe();
    step("post_reset", 32'hFFFF_FFFF, 32'h0000_0002, 2'b00, 2'b10);
    for (int i = 0; i < 40; i++)
      step("random2", $urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    for (int i = 0; i < LAT; i++)
      step("drain", 32'h0, 32'h0, 2'b00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_32bit_precion_control.md
MUL_32BIT_PRECION_CONTROL -- requirements
Module: mul_32bit_precion_control

Interface
REQ-001 The block SHALL have no parameters; lane width SHALL be selected at run time by precision_reg.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 The block SHALL have port: clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port: rst  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port: operand_a_reg  input  32  operand A, packed lanes.
REQ-006 The block SHALL have port: operand_b_reg  input  32  operand B, packed lanes.
REQ-007 The block SHALL have port: opcode_reg  input  2  00 MUL, 01 MULH, 10 MULHU, 11 MULHSU.
REQ-008 The block SHALL have port: precision_reg  input  2  00 8-bit x4, 01 16-bit x2, 10 32-bit x1, 11 32-bit x1.
REQ-009 The block SHALL have port: mul_out  output  32  packed lane results.

Function
REQ-010 The block SHALL capture operand_a_reg, operand_b_reg, opcode_reg and precision_reg into input registers on every rising clk.
REQ-011 The block SHALL split both operands into N independent lanes of width W (W=8/16/32, N=32/W); lane i SHALL occupy bits [W*i+W-1 : W*i], and no carry or sign SHALL cross a lane boundary.
REQ-012 The block SHALL form a 2W-bit full product per lane: MUL signed x signed (low half is sign-agnostic), MULH signed x signed, MULHU unsigned x unsigned, MULHSU A signed x B unsigned.
REQ-013 The block SHALL return the low W bits of the 2W-bit product for MUL.
REQ-014 The block SHALL return the high W bits of the 2W-bit product for MULH, MULHU and MULHSU.
REQ-015 The block SHALL sign-extend lane sign for signed operands from bit W-1 of each lane.
REQ-016 The block SHALL build its core from Urdhva-Tiryakbhyam (vertical/crosswise) partial-product 8x8 units reused by lane; an equivalent * operator result is acceptable provided the outputs match bit-exactly.
REQ-017 With the output register present, the block SHALL present the result on mul_out after the second rising clk following application of the inputs (latency 2), and SHALL hold it stable between edges.
REQ-018 The block SHALL accept new operands every cycle (throughput 1), with no handshake.
REQ-019 A change of opcode or precision SHALL affect only results for operands captured in the same cycle.
REQ-020 Boundary values SHALL wrap modulo 2^W per lane: MUL 8-bit 0x80*0x80 -> 0x00 per lane; signed most-negative squared MULH 8-bit -> 0x40.

Reset
REQ-021 While rst=0, all input registers and the output register SHALL clear to 0 asynchronously, and mul_out SHALL read 0x00000000.
REQ-022 After rst rises, the first valid mul_out SHALL appear per REQ-017; any operation in flight when reset is asserted SHALL be discarded.

Configuration
REQ-023 Macro MUL_OUTPUT_REG_EN: when defined, mul_out SHALL be driven by a reset-able output register (latency 2).
REQ-024 When MUL_OUTPUT_REG_EN is undefined, mul_out SHALL be combinational from the input registers (latency 1), and the reset value of the input registers SHALL still give mul_out=0.

Verification
REQ-025 The bench SHALL apply precision 10, opcode 00, A=0xFFFFFFFF, B=0x00000002 -> mul_out=0xFFFFFFFE.
REQ-026 The bench SHALL apply precision 00, opcode 10, A=0xFFFFFFFF, B=0xFFFFFFFF -> mul_out=0xFEFEFEFE.
REQ-027 The bench SHALL apply precision 00, opcode 01, A=0x80808080, B=0x80808080 -> mul_out=0x40404040, and with opcode 00 -> 0x00000000.
REQ-028 The bench SHALL apply precision 01, opcode 11, A=0xFFFFFFFF, B=0xFFFFFFFF -> mul_out=0xFFFFFFFF, and with opcode 10 -> 0xFFFEFFFE.
REQ-029 The bench SHALL apply precision 10, opcode 01, A=0x80000000, B=0x80000000 -> mul_out=0x40000000.
REQ-030 The bench SHALL assert rst=0 mid-stream with nonzero operands -> mul_out=0x00000000 immediately (asynchronously), with correct results resuming at the latency of REQ-017 after release.
